// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter/sequencer sharing one frame_transmission engine among NUM_REQ requesters.
// Define TX_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that drives the sticky err_timeout flag.
module tx_frame_arbiter #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned IFG_CYCLES     = 12,
  parameter  int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ADDR_W         = 48,
  localparam int unsigned TYPE_W         = 16,
  localparam int unsigned DATA_W         = 32,
  localparam int unsigned IDX_W          = 3,
  localparam int unsigned CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_enable,
  input  logic [ADDR_W-1:0]         cfg_src_addr,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest_addr,
  input  logic [NUM_REQ*TYPE_W-1:0] req_eth_type,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [ADDR_W-1:0]         ft_dest_addr,
  output logic [ADDR_W-1:0]         ft_src_addr,
  output logic [TYPE_W-1:0]         ft_eth_type,
  output logic [DATA_W-1:0]         ft_data,
  output logic                      ft_start,
  input  logic                      ft_tx_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          cur_grant,
  output logic [CNT_W-1:0]          frames_sent,
  output logic                      err_timeout
);

  localparam int unsigned IFG_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("tx_frame_arbiter: NUM_REQ must lie in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("tx_frame_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    IFG       = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src;
    logic [TYPE_W-1:0] eth_type;
    logic [DATA_W-1:0] data;
  } desc_t;

  state_e             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IFG_W-1:0]   ifg_cnt, ifg_cnt_d;
  desc_t              desc_q, desc_d, sel_desc;
  logic [NUM_REQ-1:0] ack_d, win_onehot;
  logic               start_d;
  logic               busy_d;
  logic [IDX_W-1:0]   grant_d;
  logic [CNT_W-1:0]   frames_d;
  logic               done_evt;

  logic [IDX_W-1:0]   win_lo, win_hi, winner;
  logic               found_lo, found_hi;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  logic            err_q, err_d;
`endif

  // Round-robin pick: lowest requester at or above ptr, else wrap to the lowest overall.
  always_comb begin : p_arb
    win_lo   = '0;
    win_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        win_lo   = IDX_W'(i);
        found_lo = 1'b1;
      end
      if (req_valid[i] && (IDX_W'(i) >= ptr) && !found_hi) begin
        win_hi   = IDX_W'(i);
        found_hi = 1'b1;
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // Descriptor mux for the winning requester.
  always_comb begin : p_sel
    sel_desc     = '0;
    win_onehot   = '0;
    sel_desc.src = cfg_src_addr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == winner) begin
        sel_desc.dest     = req_dest_addr[i*ADDR_W +: ADDR_W];
        sel_desc.eth_type = req_eth_type[i*TYPE_W +: TYPE_W];
        sel_desc.data     = req_data[i*DATA_W +: DATA_W];
        win_onehot[i]     = 1'b1;
      end
    end
  end

  always_comb begin : p_next
    state_d   = state;
    ptr_d     = ptr;
    ifg_cnt_d = ifg_cnt;
    desc_d    = desc_q;
    ack_d     = '0;
    start_d   = 1'b0;
    grant_d   = cur_grant;
    frames_d  = frames_sent;
    done_evt  = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    wd_cnt_d  = wd_cnt;
    err_d     = err_q;
`endif
    case (state)
      IDLE: begin
        if (cfg_enable && found_lo) begin
          state_d = START;
          desc_d  = sel_desc;
          ack_d   = win_onehot;
          start_d = 1'b1;
          grant_d = winner;
          ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
      end
      START: begin
        state_d = WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        if (ft_tx_done) begin
          frames_d = frames_sent + CNT_W'(1);
          done_evt = 1'b1;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          done_evt = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
`endif
        if (done_evt) begin
          if (IFG_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = IFG;
            ifg_cnt_d = IFG_W'(IFG_CYCLES);
          end
        end
      end
      IFG: begin
        ifg_cnt_d = ifg_cnt - IFG_W'(1);
        if (ifg_cnt <= IFG_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      ifg_cnt     <= '0;
      desc_q      <= '0;
      req_ack     <= '0;
      ft_start    <= 1'b0;
      busy        <= 1'b0;
      cur_grant   <= '0;
      frames_sent <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      ifg_cnt     <= ifg_cnt_d;
      desc_q      <= desc_d;
      req_ack     <= ack_d;
      ft_start    <= start_d;
      busy        <= busy_d;
      cur_grant   <= grant_d;
      frames_sent <= frames_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin : p_wd
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign ft_dest_addr = desc_q.dest;
  assign ft_src_addr  = desc_q.src;
  assign ft_eth_type  = desc_q.eth_type;
  assign ft_data      = desc_q.data;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: grants checked by a monitor, timing checked inline.
module tb_tx_frame_arbiter;
  localparam int unsigned NUM_REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_enable;
  logic [47:0]           cfg_src_addr;
  logic [NUM_REQ-1:0]    req_valid, req_ack;
  logic [NUM_REQ*48-1:0] req_dest_addr;
  logic [NUM_REQ*16-1:0] req_eth_type;
  logic [NUM_REQ*32-1:0] req_data;
  logic [47:0]           ft_dest_addr, ft_src_addr;
  logic [15:0]           ft_eth_type;
  logic [31:0]           ft_data;
  logic                  ft_start, ft_tx_done, busy, err_timeout;
  logic [2:0]            cur_grant;
  logic [15:0]           frames_sent;

  logic                  cfg_enable0;
  logic [NUM_REQ-1:0]    req_valid0, req_ack0;
  logic [47:0]           ft0_dest, ft0_src;
  logic [15:0]           ft0_type;
  logic [31:0]           ft0_data;
  logic                  ft_start0, ft_tx_done0, busy0, err_timeout0;
  logic [2:0]            cur_grant0;
  logic [15:0]           frames_sent0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [NUM_REQ-1:0] ack;
    logic [2:0]         grant;
    logic [47:0]        dest;
    logic [47:0]        src;
    logic [15:0]        etype;
    logic [31:0]        data;
  } exp_t;

  exp_t exp_q[$];

  tx_frame_arbiter #(.NUM_REQ(NUM_REQ), .IFG_CYCLES(12), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_src_addr(cfg_src_addr),
    .req_valid(req_valid), .req_dest_addr(req_dest_addr), .req_eth_type(req_eth_type),
    .req_data(req_data), .req_ack(req_ack), .ft_dest_addr(ft_dest_addr),
    .ft_src_addr(ft_src_addr), .ft_eth_type(ft_eth_type), .ft_data(ft_data),
    .ft_start(ft_start), .ft_tx_done(ft_tx_done), .busy(busy), .cur_grant(cur_grant),
    .frames_sent(frames_sent), .err_timeout(err_timeout)
  );

  tx_frame_arbiter #(.NUM_REQ(NUM_REQ), .IFG_CYCLES(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable0), .cfg_src_addr(cfg_src_addr),
    .req_valid(req_valid0), .req_dest_addr(req_dest_addr), .req_eth_type(req_eth_type),
    .req_data(req_data), .req_ack(req_ack0), .ft_dest_addr(ft0_dest),
    .ft_src_addr(ft0_src), .ft_eth_type(ft0_type), .ft_data(ft0_data),
    .ft_start(ft_start0), .ft_tx_done(ft_tx_done0), .busy(busy0), .cur_grant(cur_grant0),
    .frames_sent(frames_sent0), .err_timeout(err_timeout0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_req(input int i, input logic [47:0] d, input logic [15:0] t,
                         input logic [31:0] da);
    req_dest_addr[i*48 +: 48] = d;
    req_eth_type[i*16 +: 16]  = t;
    req_data[i*32 +: 32]      = da;
  endtask

  function automatic exp_t mk_exp(input int i, input logic [47:0] d, input logic [15:0] t,
                                  input logic [31:0] da);
    exp_t e;
    e.ack    = '0;
    e.ack[i] = 1'b1;
    e.grant  = 3'(i);
    e.dest   = d;
    e.src    = cfg_src_addr;
    e.etype  = t;
    e.data   = da;
    return e;
  endfunction

  function automatic logic [47:0] rr_dest(input int i); return 48'h0050_C200_0000 + 48'(i); endfunction
  function automatic logic [15:0] rr_type(input int i); return 16'h88B5 + 16'(i); endfunction
  function automatic logic [31:0] rr_data(input int i); return 32'hC0DE_0000 + 32'(i * 17); endfunction

  // Waits for a grant on dut (sel=0) or dut0 (sel=1); lat counts cycles from the call.
  task automatic wait_ack(input bit sel, input string name, output int lat);
    logic [NUM_REQ-1:0] a;
    a   = '0;
    lat = 0;
    while (a == '0 && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      a = sel ? req_ack0 : req_ack;
    end
    chk({name, "_ack_seen"}, 64'(a != '0), 64'(1));
  endtask

  task automatic pulse_done();
    ft_tx_done = 1'b1;
    @(posedge clk);
    #1 ft_tx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  // Monitor: every grant pops one expected descriptor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req_ack != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_ack: got %b expected no grant", req_ack);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ack",   64'(req_ack),      64'(e.ack));
          chk("sb_grant", 64'(cur_grant),    64'(e.grant));
          chk("sb_start", 64'(ft_start),     64'(1));
          chk("sb_dest",  64'(ft_dest_addr), 64'(e.dest));
          chk("sb_src",   64'(ft_src_addr),  64'(e.src));
          chk("sb_type",  64'(ft_eth_type),  64'(e.etype));
          chk("sb_data",  64'(ft_data),      64'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int lat, n, prev_cyc;
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_enable0 = 1'b1;
    cfg_src_addr = 48'hABCDEF123456;
    req_valid = '0; req_valid0 = '0; ft_tx_done = 1'b0; ft_tx_done0 = 1'b0;
    req_dest_addr = '0; req_eth_type = '0; req_data = '0;
    prev_cyc = 0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",    64'(req_ack),      64'(0));
    chk("rst_start",  64'(ft_start),     64'(0));
    chk("rst_busy",   64'(busy),         64'(0));
    chk("rst_grant",  64'(cur_grant),    64'(0));
    chk("rst_frames", 64'(frames_sent),  64'(0));
    chk("rst_dest",   64'(ft_dest_addr), 64'(0));
    chk("rst_err",    64'(err_timeout),  64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request from requester 2
    cfg_enable = 1'b1;
    set_req(2, 48'h123456789ABC, 16'h0800, 32'hDEADBEEF);
    exp_q.push_back(mk_exp(2, 48'h123456789ABC, 16'h0800, 32'hDEADBEEF));
    req_valid = 4'b0100;
    wait_ack(1'b0, "t1", lat);
    chk("t1_latency", 64'(lat), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    set_req(2, 48'h0, 16'h0, 32'h0);
    @(negedge clk);
    chk("t1_start_low", 64'(ft_start),     64'(0));
    chk("t1_ack_low",   64'(req_ack),      64'(0));
    chk("t1_dest_hold", 64'(ft_dest_addr), 64'h123456789ABC);
    chk("t1_data_hold", 64'(ft_data),      64'hDEADBEEF);
    repeat (39) @(posedge clk);
    #1 pulse_done();
    @(negedge clk);
    chk("t1_frames", 64'(frames_sent), 64'(1));
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("t1_ifg_len", 64'(n), 64'(12));

    // Reset to bring the pointer back to 0
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst2_frames", 64'(frames_sent), 64'(0));

    // Round robin with all four held
    for (int i = 0; i < 4; i++) set_req(i, rr_dest(i), rr_type(i), rr_data(i));
    for (int i = 0; i < 5; i++) exp_q.push_back(mk_exp(i % 4, rr_dest(i % 4), rr_type(i % 4), rr_data(i % 4)));
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(1'b0, "rr", lat);
      if (g > 0) chk("rr_start_gap", 64'(cyc - prev_cyc), 64'(19));
      prev_cyc = cyc;
      @(posedge clk); #1;
      if (g == 4) req_valid = '0;
      repeat (4) @(posedge clk);
      #1 pulse_done();
    end
    wait_idle("rr");
    chk("rr_frames", 64'(frames_sent), 64'(5));

    // cfg_enable gating
    @(posedge clk); #1;
    cfg_enable = 1'b0;
    set_req(0, 48'h0A0B0C0D0E0F, 16'h86DD, 32'h01234567);
    req_valid = 4'b0001;
    repeat (5) @(negedge clk);
    chk("en_off_ack",  64'(req_ack), 64'(0));
    chk("en_off_busy", 64'(busy),    64'(0));
    @(posedge clk); #1;
    cfg_enable = 1'b1;
    exp_q.push_back(mk_exp(0, 48'h0A0B0C0D0E0F, 16'h86DD, 32'h01234567));
    wait_ack(1'b0, "en_on", lat);
    chk("en_on_latency", 64'(lat), 64'(1));
    @(posedge clk); #1;
    cfg_enable = 1'b0;
    req_valid  = '0;
    repeat (3) @(posedge clk);
    #1 pulse_done();
    @(negedge clk);
    chk("en_midframe_frames", 64'(frames_sent), 64'(6));
    wait_idle("en");
    cfg_enable = 1'b1;

    // ft_tx_done during START is ignored
    @(posedge clk); #1;
    set_req(1, 48'h665544332211, 16'h0806, 32'h5A5A5A5A);
    exp_q.push_back(mk_exp(1, 48'h665544332211, 16'h0806, 32'h5A5A5A5A));
    req_valid = 4'b0010;
    wait_ack(1'b0, "st", lat);
    ft_tx_done = 1'b1;
    @(posedge clk); #1;
    ft_tx_done = 1'b0;
    req_valid  = '0;
    repeat (4) @(negedge clk);
    chk("st_busy",   64'(busy),        64'(1));
    chk("st_frames", 64'(frames_sent), 64'(6));
    pulse_done();
    @(negedge clk);
    chk("st_frames_done", 64'(frames_sent), 64'(7));
    wait_idle("st");

    // IFG_CYCLES=0 instance returns to IDLE right after done
    @(posedge clk); #1 req_valid0 = 4'b0001;
    wait_ack(1'b1, "z", lat);
    chk("z_grant", 64'(cur_grant0), 64'(0));
    @(posedge clk); #1 req_valid0 = '0;
    repeat (2) @(posedge clk);
    #1 ft_tx_done0 = 1'b1;
    @(negedge clk);
    chk("z_busy_before", 64'(busy0), 64'(1));
    @(posedge clk); #1 ft_tx_done0 = 1'b0;
    @(negedge clk);
    chk("z_busy_after", 64'(busy0),        64'(0));
    chk("z_frames",     64'(frames_sent0), 64'(1));

    // Reset asserted while waiting for done
    @(posedge clk); #1;
    set_req(0, 48'h111111111111, 16'h0800, 32'h00000001);
    exp_q.push_back(mk_exp(0, 48'h111111111111, 16'h0800, 32'h00000001));
    req_valid = 4'b0001;
    wait_ack(1'b0, "wr", lat);
    @(posedge clk); #1;
    set_req(3, 48'h333333333333, 16'h0842, 32'h33333333);
    req_valid = 4'b1000;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rst_start",  64'(ft_start),     64'(0));
    chk("wr_rst_busy",   64'(busy),         64'(0));
    chk("wr_rst_ack",    64'(req_ack),      64'(0));
    chk("wr_rst_grant",  64'(cur_grant),    64'(0));
    chk("wr_rst_frames", 64'(frames_sent),  64'(0));
    chk("wr_rst_dest",   64'(ft_dest_addr), 64'(0));
    chk("wr_rst_data",   64'(ft_data),      64'(0));
    exp_q.push_back(mk_exp(3, 48'h333333333333, 16'h0842, 32'h33333333));
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ack(1'b0, "wr_post", lat);
    chk("wr_post_latency", 64'(lat), 64'(1));
    @(posedge clk); #1 req_valid = '0;
    repeat (2) @(posedge clk);
    #1 pulse_done();
    @(negedge clk);
    chk("wr_post_frames", 64'(frames_sent), 64'(1));
    wait_idle("wr");

`ifdef TX_ARB_TIMEOUT_EN
    // Watchdog on dut0 (TIMEOUT_CYCLES=16), no done ever driven
    @(posedge clk); #1 req_valid0 = 4'b0001;
    wait_ack(1'b1, "to", lat);
    @(posedge clk); #1 req_valid0 = '0;
    repeat (15) @(negedge clk);
    @(negedge clk);
    chk("to_err_early", 64'(err_timeout0), 64'(0));
    @(negedge clk);
    chk("to_err_set",  64'(err_timeout0), 64'(1));
    chk("to_frames",   64'(frames_sent0), 64'(0));
    chk("to_busy",     64'(busy0),        64'(0));
    @(posedge clk); #1 req_valid0 = 4'b0001;
    wait_ack(1'b1, "to_next", lat);
    chk("to_next_latency", 64'(lat), 64'(1));
    @(posedge clk); #1 req_valid0 = '0;
    ft_tx_done0 = 1'b1;
    @(posedge clk); #1 ft_tx_done0 = 1'b0;
    @(negedge clk);
    chk("to_next_frames", 64'(frames_sent0), 64'(1));
    chk("to_err_sticky",  64'(err_timeout0), 64'(1));
`else
    chk("err_tied_low",  64'(err_timeout),  64'(0));
    chk("err0_tied_low", 64'(err_timeout0), 64'(0));
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
